// File: rtl/credit_pkg.sv
// Shared types and widths for the arcade credit controller.
// The score display also uses CREDIT_W.
package credit_pkg;

    localparam int CREDIT_W = 7;

    typedef enum logic [2:0] {
        ATTRACT,
        READY,
        LAUNCH,
        PLAYING,
        HOLDOFF
    } credit_state_t;

endpackage

// File: rtl/bin2bcd99.sv
// Combinational 7-bit binary to two BCD digits for values 0..99.
// It finds the tens digit with a compare ladder and the units digit by subtraction, so no divider is needed.
module bin2bcd99
    import credit_pkg::*;
(
    input  logic [CREDIT_W-1:0] bin_i,
    output logic [3:0]          tens_o,
    output logic [3:0]          units_o
);

    // The highest decade threshold that the input reaches sets the tens digit.
    always_comb begin
        tens_o  = 4'd0;
        units_o = 4'(bin_i);
        for (int k = 1; k <= 9; k++) begin
            if (bin_i >= CREDIT_W'(10 * k)) begin
                tens_o  = 4'(k);
                units_o = 4'(bin_i - CREDIT_W'(10 * k));
            end
        end
    end

endmodule

// File: rtl/credit_controller.sv
// Arcade credit controller. It counts coins, spends one credit per game start and hands control to the game FSM.
// It also drives the BCD credit display and the coin-accepted LED.
module credit_controller
    import credit_pkg::*;
#(
    parameter int MAX_CREDITS   = 99,
    parameter int FLASH_CYCLES  = 25000000,
    parameter int START_HOLDOFF = 50
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                coin_pulse,
    input  logic                start_pulseN,
    input  logic                game_over,
    output logic                start_game,
    output logic                playing,
    output logic [CREDIT_W-1:0] credits,
    output logic [3:0]          credit_tens,
    output logic [3:0]          credit_units,
    output logic                coin_lockout,
    output logic                coin_led
);

    localparam int FLASH_W = (FLASH_CYCLES > 0) ? $clog2(FLASH_CYCLES + 1) : 1;
    localparam int HOLD_W  = (START_HOLDOFF > 0) ? $clog2(START_HOLDOFF + 1) : 1;
    localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDITS);

    credit_state_t       state_q, state_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic [FLASH_W-1:0]  flash_q, flash_d;
    logic [HOLD_W-1:0]   holdoff_q, holdoff_d;
    logic                start_game_q, start_game_d;
    logic                playing_q, playing_d;
    logic                lockout_q, lockout_d;
    logic                led_q, led_d;
    logic [3:0]          tens_q, tens_d;
    logic [3:0]          units_q, units_d;
    logic                coinAccept;
    logic                creditTake;

    // The display digits come from the next credit value, so they change on the same edge as the count.
    bin2bcd99 u_bcd (
        .bin_i   (credits_d),
        .tens_o  (tens_d),
        .units_o (units_d)
    );

    // A coin is dropped at saturation. If a start arrives in the same cycle, it still spends a credit.
    always_comb begin
        coinAccept   = coin_pulse && (credits_q < MAX_C);
        creditTake   = 1'b0;
        state_d      = state_q;
        holdoff_d    = holdoff_q;
        start_game_d = 1'b0;

        case (state_q)
            ATTRACT: begin
                if (coinAccept || (credits_q != '0)) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (!start_pulseN && (credits_q != '0)) begin
                    state_d      = LAUNCH;
                    creditTake   = 1'b1;
                    start_game_d = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = PLAYING;
            end
            PLAYING: begin
                if (game_over) begin
                    state_d   = HOLDOFF;
                    holdoff_d = HOLD_W'(START_HOLDOFF);
                end
            end
            HOLDOFF: begin
                if (holdoff_q <= HOLD_W'(1)) begin
                    holdoff_d = '0;
                    state_d   = (coinAccept || (credits_q != '0)) ? READY : ATTRACT;
                end else begin
                    holdoff_d = holdoff_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = ATTRACT;
            end
        endcase

        credits_d = credits_q + CREDIT_W'(coinAccept) - CREDIT_W'(creditTake);
        lockout_d = (credits_d == MAX_C);
        playing_d = (state_d == PLAYING);

        if (coinAccept) begin
            flash_d = FLASH_W'(FLASH_CYCLES);
        end else if (flash_q != '0) begin
            flash_d = flash_q - FLASH_W'(1);
        end else begin
            flash_d = '0;
        end
        led_d = (flash_d != '0);
    end

    // Every output is registered. Reset abandons any game in progress and does not refund the credit.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= ATTRACT;
            credits_q    <= '0;
            flash_q      <= '0;
            holdoff_q    <= '0;
            start_game_q <= 1'b0;
            playing_q    <= 1'b0;
            lockout_q    <= 1'b0;
            led_q        <= 1'b0;
            tens_q       <= 4'd0;
            units_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            credits_q    <= credits_d;
            flash_q      <= flash_d;
            holdoff_q    <= holdoff_d;
            start_game_q <= start_game_d;
            playing_q    <= playing_d;
            lockout_q    <= lockout_d;
            led_q        <= led_d;
            tens_q       <= tens_d;
            units_q      <= units_d;
        end
    end

    assign start_game   = start_game_q;
    assign playing      = playing_q;
    assign credits      = credits_q;
    assign credit_tens  = tens_q;
    assign credit_units = units_q;
    assign coin_lockout = lockout_q;
    assign coin_led     = led_q;

endmodule
